line_buf_ctrl: RTL

- Sequencing controller for the two-bank CCD row line buffer (RAM A / RAM B) that feeds the Bayer demosaic stage.
- Counts incoming pixels and lines, and alternates the write bank on every line.
- Issues same-address reads of the previous line from the opposite bank.
- Produces row/column phase selects, an output-valid strobe, frame_end and a short-frame error.

---
 rtl/line_buf_pkg.sv | 27 ++
 rtl/lb_pix_cnt.sv | 47 ++++
 rtl/line_buf_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/line_buf_pkg.sv
// Shared types and constants for the two-bank CCD line buffer controller.
//   lb_state_e : controller states
//   BANK_A/B   : write-bank encodings
//   RD_LAT     : RAM read latency in clocks
//   pix_tag_t  : per-pixel side-band that travels alongside the RAM read
package line_buf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } lb_state_e;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  localparam int unsigned RD_LAT = 1;

  typedef struct packed {
    logic       ov;
    logic       last;
    logic [1:0] cur;
    logic [1:0] prev;
  } pix_tag_t;

endpackage

// File: rtl/lb_pix_cnt.sv
// Column/line counter for the line buffer controller.
//   clr          : restart at col 0 / line 0 (with inc: the restart pixel is consumed)
//   inc          : advance one pixel, wrapping col at LINE_W-1 and line at LINES-1
//   col, line    : registered position of the next pixel
//   line_last_c  : col is the last column
//   frame_last_c : col/line is the last pixel of the frame
module lb_pix_cnt #(
  parameter int unsigned LINE_W     = 640,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LINES      = 480,
  parameter int unsigned LINE_CNT_W = 9
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_W-1:0]     col,
  output logic [LINE_CNT_W-1:0] line,
  output logic                  line_last_c,
  output logic                  frame_last_c
);

  localparam logic [ADDR_W-1:0]     COL_LAST  = ADDR_W'(LINE_W - 1);
  localparam logic [LINE_CNT_W-1:0] LINE_LAST = LINE_CNT_W'(LINES - 1);

  assign line_last_c  = (col == COL_LAST);
  assign frame_last_c = line_last_c && (line == LINE_LAST);

  // Position register
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      col  <= '0;
      line <= '0;
    end else if (clr) begin
      col  <= inc ? ADDR_W'(1) : '0;
      line <= '0;
    end else if (inc) begin
      if (line_last_c) begin
        col  <= '0;
        line <= (line == LINE_LAST) ? '0 : line + LINE_CNT_W'(1);
      end else begin
        col  <= col + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/line_buf_ctrl.sv
// Sequencing controller for the two-bank (A/B) CCD row line buffer feeding demosaic.
// Writes each line into alternating banks and reads the previous line from the
// opposite bank at the same column; pixel side-band is delayed to line up with
// the RAM read data.
// Optional feature macro: LINE_BUF_CTRL_FLUSH_EN (drains the last line after the frame).
// Ports:
//   clk, aclr_n                 : pixel clock, async active-low reset
//   frame_start, pix_valid      : frame pulse, pixel accept strobe
//   rama_wren, ramb_wren        : per-bank write enables, ram_wraddr shared address
//   rama_rden, ramb_rden        : per-bank read enables, ram_rdaddr shared address
//   out_valid                   : read data + live pixel valid for demosaic
//   sel_row_cur, sel_row_prev   : {line parity, column parity} of current/previous row
//   line_idx                    : line being written
//   frame_end, err_short_frame  : one-cycle status pulses
module line_buf_ctrl
  import line_buf_pkg::*;
#(
  parameter int unsigned LINE_W     = 640,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LINES      = 480,
  parameter int unsigned LINE_CNT_W = 9
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  output logic                  rama_wren,
  output logic                  ramb_wren,
  output logic [ADDR_W-1:0]     ram_wraddr,
  output logic                  rama_rden,
  output logic                  ramb_rden,
  output logic [ADDR_W-1:0]     ram_rdaddr,
  output logic                  out_valid,
  output logic [1:0]            sel_row_cur,
  output logic [1:0]            sel_row_prev,
  output logic [LINE_CNT_W-1:0] line_idx,
  output logic                  frame_end,
  output logic                  err_short_frame
);

`ifdef LINE_BUF_CTRL_FLUSH_EN
  // Flush reads present the drained line as the virtual line after the last one
  localparam logic FLUSH_LP = 1'((LINES % 2) != 0);
`endif

  lb_state_e         state_q, state_d;
  logic              bank_q, bank_d, wbank_d;
  logic              cnt_clr, cnt_inc;
  logic              wr_d, rd_d, err_d;
  logic [ADDR_W-1:0] col, addr_d;
  logic              line_last_c, frame_last_c;
  pix_tag_t          tag_d;
  pix_tag_t          tag_q [RD_LAT+1];

  lb_pix_cnt #(
    .LINE_W    (LINE_W),
    .ADDR_W    (ADDR_W),
    .LINES     (LINES),
    .LINE_CNT_W(LINE_CNT_W)
  ) u_pix_cnt (
    .clk         (clk),
    .aclr_n      (aclr_n),
    .clr         (cnt_clr),
    .inc         (cnt_inc),
    .col         (col),
    .line        (line_idx),
    .line_last_c (line_last_c),
    .frame_last_c(frame_last_c)
  );

  // Next state, bank and pixel-stage controls
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    wbank_d  = bank_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    err_d    = 1'b0;
    addr_d   = col;
    tag_d    = '{ov: 1'b0, last: 1'b0,
                 cur: {line_idx[0], col[0]}, prev: {~line_idx[0], col[0]}};

    case (state_q)
      FIRST: begin
        if (pix_valid) begin
          wr_d    = 1'b1;
          cnt_inc = 1'b1;
          if (line_last_c) begin
            bank_d  = ~bank_q;
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (pix_valid) begin
          wr_d    = 1'b1;
          rd_d    = 1'b1;
          cnt_inc = 1'b1;
          if (line_last_c) bank_d = ~bank_q;
          if (frame_last_c) begin
`ifdef LINE_BUF_CTRL_FLUSH_EN
            state_d = FLUSH;
`else
            state_d    = IDLE;
            tag_d.last = 1'b1;
`endif
          end
        end
      end
`ifdef LINE_BUF_CTRL_FLUSH_EN
      // bank_q already toggled past the last line, so the read side is the last-written bank
      FLUSH: begin
        rd_d      = 1'b1;
        tag_d.cur = {FLUSH_LP, col[0]};
        tag_d.prev = {~FLUSH_LP, col[0]};
        if (line_last_c) begin
          tag_d.last = 1'b1;
          cnt_clr    = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
`endif
      default: ;
    endcase

    // frame_start restarts the frame; a coincident final pixel still finishes the old one
    if (frame_start) begin
      if (state_q == STREAM && pix_valid && frame_last_c) begin
        tag_d.last = 1'b1;
        state_d    = FIRST;
        bank_d     = BANK_A;
        cnt_clr    = 1'b1;
        cnt_inc    = 1'b0;
      end else begin
        err_d      = (state_q != IDLE);
        state_d    = FIRST;
        bank_d     = BANK_A;
        wbank_d    = BANK_A;
        cnt_clr    = 1'b1;
        cnt_inc    = pix_valid;
        wr_d       = pix_valid;
        rd_d       = 1'b0;
        addr_d     = '0;
        tag_d.last = 1'b0;
      end
    end

    tag_d.ov = rd_d;
  end

  // State, RAM-side outputs and side-band pipeline
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q         <= IDLE;
      bank_q          <= BANK_A;
      rama_wren       <= 1'b0;
      ramb_wren       <= 1'b0;
      rama_rden       <= 1'b0;
      ramb_rden       <= 1'b0;
      ram_wraddr      <= '0;
      ram_rdaddr      <= '0;
      err_short_frame <= 1'b0;
      for (int unsigned i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      bank_q          <= bank_d;
      rama_wren       <= wr_d && (wbank_d == BANK_A);
      ramb_wren       <= wr_d && (wbank_d == BANK_B);
      rama_rden       <= rd_d && (wbank_d == BANK_B);
      ramb_rden       <= rd_d && (wbank_d == BANK_A);
      if (wr_d) ram_wraddr <= addr_d;
      if (rd_d) ram_rdaddr <= addr_d;
      err_short_frame <= err_d;
      tag_q[0]        <= tag_d;
      for (int unsigned i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign out_valid    = tag_q[RD_LAT].ov;
  assign frame_end    = tag_q[RD_LAT].last;
  assign sel_row_cur  = tag_q[RD_LAT].cur;
  assign sel_row_prev = tag_q[RD_LAT].prev;

endmodule
